// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad emulator.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } state_t;

  // Row returns float high when no key connects them to a strobed column.
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Physical (row,col) of each hex key code on the 4x4 matrix; * is 0xE, # is 0xF.
  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t p;
    p = '0;
    case (key)
      4'h1: p = {2'd0, 2'd0};
      4'h2: p = {2'd0, 2'd1};
      4'h3: p = {2'd0, 2'd2};
      4'hA: p = {2'd0, 2'd3};
      4'h4: p = {2'd1, 2'd0};
      4'h5: p = {2'd1, 2'd1};
      4'h6: p = {2'd1, 2'd2};
      4'hB: p = {2'd1, 2'd3};
      4'h7: p = {2'd2, 2'd0};
      4'h8: p = {2'd2, 2'd1};
      4'h9: p = {2'd2, 2'd2};
      4'hC: p = {2'd2, 2'd3};
      4'hE: p = {2'd3, 2'd0};
      4'h0: p = {2'd3, 2'd1};
      4'hF: p = {2'd3, 2'd2};
      4'hD: p = {2'd3, 2'd3};
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_emulator_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, realigned by restart.
module tick_gen #(
  parameter int TICK_DIV = 500
) (
  input  logic clk,
  input  logic Reset,
  input  logic restart,
  output logic tick
);

  localparam int DIV = (TICK_DIV < 1) ? 1 : TICK_DIV;
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..DIV-1; restart zeroes it so the first tick lands DIV cycles later.
  always_ff @(posedge clk) begin
    if (!Reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad emulator: plays one bouncing key press per command
// back to a column-scanning reader.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 500,
  parameter int BOUNCE_TOGGLES = 3,
  parameter int BOUNCE_TICKS   = 2,
  parameter int GAP_TICKS      = 4
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic [3:0]  cols,
  output logic [3:0]  rows,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] BT_LAST  = 16'(((BOUNCE_TICKS < 1) ? 1 : BOUNCE_TICKS) - 1);
  localparam logic [15:0] TOG_LAST = 16'(BOUNCE_TOGGLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);
  localparam bit SKIP_BOUNCE = (BOUNCE_TOGGLES == 0);
  localparam bit SKIP_GAP    = (GAP_TICKS == 0);

  state_t      state;
  logic [3:0]  key_r;
  logic [15:0] hold_r;
  logic [15:0] phase_cnt;
  logic [15:0] toggle_cnt;
  logic        second_half;
  logic        tick;
  logic        accept;
  logic        contact;
  key_pos_t    pos;
  logic        col_ok;
  logic [1:0]  col_sel;
  logic [3:0]  rows_next;

  assign accept = cmd_valid && cmd_ready;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (CLOCK_50),
    .Reset   (Reset),
    .restart (accept),
    .tick    (tick)
  );

  // Press sequencer: accept, bounce in, hold, bounce out, release gap, done.
  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      key_r       <= '0;
      hold_r      <= '0;
      phase_cnt   <= '0;
      toggle_cnt  <= '0;
      second_half <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            key_r       <= cmd_key;
            hold_r      <= (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
            phase_cnt   <= '0;
            toggle_cnt  <= '0;
            second_half <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= SKIP_BOUNCE ? ST_HOLD : ST_BOUNCE_IN;
          end
        end
        // Both bounce states share the half-phase/toggle counting; only the
        // contact polarity of each half differs (see contact decode).
        ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
          if (tick) begin
            if (phase_cnt != BT_LAST) begin
              phase_cnt <= phase_cnt + 16'd1;
            end else begin
              phase_cnt   <= '0;
              second_half <= ~second_half;
              if (second_half) begin
                if (toggle_cnt != TOG_LAST) begin
                  toggle_cnt <= toggle_cnt + 16'd1;
                end else begin
                  toggle_cnt <= '0;
                  if (state == ST_BOUNCE_IN) begin
                    state <= ST_HOLD;
                  end else if (SKIP_GAP) begin
                    state     <= ST_IDLE;
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                  end else begin
                    state <= ST_GAP;
                  end
                end
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (phase_cnt != hold_r - 16'd1) begin
              phase_cnt <= phase_cnt + 16'd1;
            end else begin
              phase_cnt <= '0;
              if (!SKIP_BOUNCE) begin
                state <= ST_BOUNCE_OUT;
              end else if (SKIP_GAP) begin
                state     <= ST_IDLE;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
              end else begin
                state <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (phase_cnt != GAP_LAST) begin
              phase_cnt <= phase_cnt + 16'd1;
            end else begin
              phase_cnt <= '0;
              state     <= ST_IDLE;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Contact is closed throughout HOLD, in the first half of each bounce-in
  // toggle and in the second half of each bounce-out toggle.
  assign contact = (state == ST_HOLD) ||
                   ((state == ST_BOUNCE_IN)  && !second_half) ||
                   ((state == ST_BOUNCE_OUT) &&  second_half);

  assign pos = key_to_pos(key_r);

  // Decode the strobed column; anything but a single low bit selects nothing.
  always_comb begin
    col_ok  = 1'b1;
    col_sel = 2'd0;
    case (cols)
      4'b0111: col_sel = 2'd0;
      4'b1011: col_sel = 2'd1;
      4'b1101: col_sel = 2'd2;
      4'b1110: col_sel = 2'd3;
      default: col_ok  = 1'b0;
    endcase
  end

  // Pull the key's row low when its column is strobed and contact is closed.
  always_comb begin
    rows_next = ROWS_IDLE;
    if (contact && col_ok && (col_sel == pos.col)) begin
      rows_next[~pos.row] = 1'b0;
    end
  end

  // Register the row returns.
  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      rows <= ROWS_IDLE;
    end else begin
      rows <= rows_next;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with hand-computed expectations.
module tb_keypad_emulator;

  logic        CLOCK_50 = 1'b0;
  logic        Reset;
  logic        cmd_valid, cmd_ready, busy, done;
  logic [3:0]  cmd_key, cols, rows;
  logic [15:0] cmd_hold;
  logic        b_cmd_valid, b_cmd_ready, b_busy, b_done;
  logic [3:0]  b_cmd_key, b_cols, b_rows;
  logic [15:0] b_cmd_hold;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  keypad_emulator #(.TICK_DIV(4), .BOUNCE_TOGGLES(0), .BOUNCE_TICKS(2), .GAP_TICKS(2)) dut (
    .CLOCK_50 (CLOCK_50), .Reset (Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
    .cols(cols), .rows(rows), .busy(busy), .done(done)
  );

  keypad_emulator #(.TICK_DIV(4), .BOUNCE_TOGGLES(2), .BOUNCE_TICKS(1), .GAP_TICKS(2)) dut_b (
    .CLOCK_50 (CLOCK_50), .Reset (Reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_key(b_cmd_key), .cmd_hold(b_cmd_hold),
    .cols(b_cols), .rows(b_rows), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One press on the main instance with a fixed column; TICK_DIV=4, GAP=2 ticks.
  task automatic press_fixed(input logic [3:0] key, input logic [15:0] hold,
                             input logic [3:0] c, input logic [3:0] exp_rows, input int eff);
    int total;
    int dones;
    total = 4 * (eff + 2);
    dones = 0;
    cmd_key = key; cmd_hold = hold; cols = c; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("accept_busy", busy, 1'b1);
    for (int n = 1; n <= total; n++) begin
      step();
      if (n <= 4 * eff) check("hold_rows", rows, exp_rows);
      else              check("release_rows", rows, 4'hF);
      if (done) dones++;
      if (n == total) check("done_at_end", done, 1'b1);
    end
    step();
    if (done) dones++;
    check("done_count", dones, 1);
    check("ready_after", cmd_ready, 1'b1);
  endtask

  function automatic logic [3:0] exp_b(input int n);
    if ((n >= 1 && n <= 4) || (n >= 9 && n <= 12) || (n >= 17 && n <= 24) ||
        (n >= 29 && n <= 32) || (n >= 37 && n <= 40))
      return 4'b0111;
    return 4'hF;
  endfunction

  initial begin
    logic [3:0] pat [4];
    int dones;
    pat = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    Reset = 1'b0;
    cmd_valid = 1'b0; cmd_key = '0; cmd_hold = '0; cols = 4'hF;
    b_cmd_valid = 1'b0; b_cmd_key = '0; b_cmd_hold = '0; b_cols = 4'hF;
    step(); step();
    check("rst_rows", rows, 4'hF);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_b_rows", b_rows, 4'hF);
    Reset = 1'b1;
    step();

    // Key 5, hold 3, columns scanned every cycle.
    cmd_key = 4'h5; cmd_hold = 16'd3; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cols = pat[0];
    for (int n = 1; n <= 24; n++) begin
      step();
      check("scan_rows", rows,
            ((n - 1) <= 11 && pat[(n - 1) % 4] == 4'b1011) ? 4'b1011 : 4'hF);
      check("scan_done", done, n == 20);
      cols = pat[n % 4];
    end
    check("scan_ready", cmd_ready, 1'b1);

    // Corner keys on their own columns, wrong/absent strobes, zero hold.
    press_fixed(4'hE, 16'd2, 4'b0111, 4'b1110, 2);
    press_fixed(4'hD, 16'd2, 4'b1110, 4'b1110, 2);
    press_fixed(4'h3, 16'd1, 4'b0011, 4'hF, 1);
    press_fixed(4'h3, 16'd1, 4'b1111, 4'hF, 1);
    press_fixed(4'h3, 16'd1, 4'b1101, 4'b0111, 1);
    press_fixed(4'h1, 16'd0, 4'b0111, 4'b0111, 1);

    // Reset in the middle of HOLD aborts without done.
    cmd_key = 4'h5; cmd_hold = 16'd3; cols = 4'b1011; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_hold_rows", rows, 4'b1011);
    Reset = 1'b0;
    step();
    check("abort_rows", rows, 4'hF);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    Reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_idle_rows", rows, 4'hF);

    // cmd_valid held high: back-to-back commands, one accept per done.
    cmd_key = 4'h2; cmd_hold = 16'd1; cols = 4'b1011; cmd_valid = 1'b1;
    for (int n = 0; n <= 64; n++) begin
      step();
      check("b2b_ready", cmd_ready, (n % 13) == 12);
      check("b2b_done", done, (n % 13) == 12);
    end
    cmd_valid = 1'b0;
    step();
    check("b2b_final_ready", cmd_ready, 1'b1);
    check("b2b_final_busy", busy, 1'b0);

    // Bouncing instance: two toggles of one tick each, key 1 on column 0.
    b_cmd_key = 4'h1; b_cmd_hold = 16'd2; b_cols = 4'b0111; b_cmd_valid = 1'b1;
    step();
    b_cmd_valid = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      step();
      check("bounce_rows", b_rows, exp_b(n));
      check("bounce_done", b_done, n == 48);
      if (n == 48) check("bounce_ready", b_cmd_ready, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
